// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   localparam int WR_COUNT_W = 16;
   localparam int BURST_W    = 4;

   // Ceiling log2, used for index and pointer widths (n >= 2 expected).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with show-ahead read data; cs qualifies the write port only.
module fifo_sync
   import fifo_arb_pkg::*;
#(
   parameter int fifo_depth = 8,
   parameter int data_width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [data_width-1:0] data_in,
   output logic [data_width-1:0] data_out,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = clog2(fifo_depth);
   localparam int CNT_W = clog2(fifo_depth + 1);

   logic [data_width-1:0] mem [fifo_depth];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  do_wr;
   logic                  do_rd;

   assign do_wr    = cs && wr_en && !full;
   assign do_rd    = rd_en && !empty;
   assign full     = (count == CNT_W'(fifo_depth));
   assign empty    = (count == '0);
   assign data_out = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == PTR_W'(fifo_depth - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(fifo_depth - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array write.
   // NOTE: the memory is deliberately not reset; pointers and count define validity, so it maps to plain RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after last_owner, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int num_req = 4,
   parameter int idx_w   = clog2(num_req)
) (
   input  logic [num_req-1:0] req,
   input  logic [idx_w-1:0]   last_owner,
   output logic               valid,
   output logic [idx_w-1:0]   idx
);

   function automatic logic [idx_w-1:0] wrap_idx(input int base, input int k);
      int s;
      s = base + k;
      if (s >= num_req) s = s - num_req;
      return idx_w'(s);
   endfunction

   // Scan offsets 1..num_req so last_owner itself is considered last.
   // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = 1; k <= num_req; k++) begin
         if (!valid && req[wrap_idx(int'(last_owner), k)]) begin
            valid = 1'b1;
            idx   = wrap_idx(int'(last_owner), k);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int num_req    = 4,
   parameter int data_width = 32,
   parameter int max_burst  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [num_req-1:0]            req,
   input  logic [num_req*data_width-1:0] req_data,
   output logic [num_req-1:0]            gnt,
   output logic                          fifo_cs,
   output logic                          fifo_wr_en,
   output logic [data_width-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   output logic [clog2(num_req)-1:0]     owner_id,
   output logic                          busy,
   output logic [WR_COUNT_W-1:0]         wr_count
);

   localparam int                 IDX_W       = clog2(num_req);
   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(max_burst);

   arb_state_t         state, state_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [IDX_W-1:0]   last_owner, last_owner_nxt;
   logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
   logic [BURST_W-1:0] burst_inc;
   logic               owner_req;
   logic               accept;
   logic               leave;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;

   // last_owner equals owner while in OWN, so the same pick naturally gives
   // a burst-limited owner that is still requesting the lowest priority.
   rr_pick #(
      .num_req (num_req),
      .idx_w   (IDX_W)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   assign owner_req = req[owner];
   assign accept    = (state == OWN) && owner_req && !fifo_full;
   assign burst_inc = burst_cnt + 1'b1;
   assign leave     = (state == OWN) && (!owner_req || (accept && (burst_inc == BURST_LIMIT)));

   // Next-state: acquire from IDLE, hand off without a bubble, or hold under back-pressure.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      burst_cnt_nxt  = burst_cnt;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nxt      = OWN;
               owner_nxt      = pick_idx;
               last_owner_nxt = pick_idx;
               burst_cnt_nxt  = '0;
            end
         end
         OWN: begin
            if (leave) begin
               if (pick_valid) begin
                  owner_nxt      = pick_idx;
                  last_owner_nxt = pick_idx;
                  burst_cnt_nxt  = '0;
               end else begin
                  state_nxt     = IDLE;
                  owner_nxt     = '0;
                  burst_cnt_nxt = '0;
               end
            end else if (accept) begin
               burst_cnt_nxt = burst_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant and FIFO write-port drive, combinational from state, req and full.
   always_comb begin
      gnt          = '0;
      fifo_data_in = '0;
      for (int i = 0; i < num_req; i++) begin
         if ((state == OWN) && (owner == IDX_W'(i))) begin
            gnt[i]       = accept;
            fifo_data_in = req_data[i*data_width +: data_width];
         end
      end
   end

   assign fifo_wr_en = |gnt;
   assign fifo_cs    = fifo_wr_en;
   assign owner_id   = owner;
   assign busy       = (state == OWN);

   // State registers; last_owner resets so requester 0 wins the first pick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IDX_W'(num_req - 1);
         burst_cnt  <= '0;
         wr_count   <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         burst_cnt  <= burst_cnt_nxt;
         if (accept) wr_count <= wr_count + WR_COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: arbiter in front of an 8-deep FIFO, table-driven per-cycle vectors.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  gnt;
   logic          fifo_cs;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_data_in;
   logic          fifo_full;
   logic [1:0]    owner_id;
   logic          busy;
   logic [15:0]   wr_count;
   logic          rd_en;
   logic [DW-1:0] data_out;
   logic          empty;

   fifo_wr_arbiter #(
      .num_req    (N),
      .data_width (DW),
      .max_burst  (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .fifo_cs      (fifo_cs),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .fifo_full    (fifo_full),
      .owner_id     (owner_id),
      .busy         (busy),
      .wr_count     (wr_count)
   );

   fifo_sync #(
      .fifo_depth (DEPTH),
      .data_width (DW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .cs       (fifo_cs),
      .wr_en    (fifo_wr_en),
      .rd_en    (rd_en),
      .data_in  (fifo_data_in),
      .data_out (data_out),
      .full     (fifo_full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       rd;
      logic [3:0] gnt;
      logic       busy;
      logic [1:0] owner;
      logic       full;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] prod_word [N];
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic [3:0] g,
                               input logic b, input logic [1:0] o, input logic f);
      vec_t v;
      v.req = r; v.rd = rd; v.gnt = g; v.busy = b; v.owner = o; v.full = f;
      return v;
   endfunction

   function automatic int oh_idx(input logic [3:0] v);
      int r;
      r = 0;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic drive_inputs(input logic [3:0] r);
      req = r;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = prod_word[i];
   endtask

   // Applies vecs[first..last-1], one clock per record; producers advance on expected grants.
   task automatic run_vecs(input string tag, input int first, input int last);
      for (int i = first; i < last; i++) begin
         drive_inputs(vecs[i].req);
         rd_en = vecs[i].rd;
         @(negedge clk);
         check($sformatf("%s[%0d].gnt", tag, i - first), 64'(gnt), 64'(vecs[i].gnt));
         check($sformatf("%s[%0d].busy", tag, i - first), 64'(busy), 64'(vecs[i].busy));
         check($sformatf("%s[%0d].owner", tag, i - first), 64'(owner_id), 64'(vecs[i].owner));
         check($sformatf("%s[%0d].full", tag, i - first), 64'(fifo_full), 64'(vecs[i].full));
         check($sformatf("%s[%0d].wr_en", tag, i - first), 64'({fifo_wr_en, fifo_cs}),
               64'({|vecs[i].gnt, |vecs[i].gnt}));
         if (vecs[i].gnt != 4'b0000)
            check($sformatf("%s[%0d].data", tag, i - first), 64'(fifo_data_in),
                  64'(prod_word[oh_idx(vecs[i].gnt)]));
         else if (!vecs[i].busy)
            check($sformatf("%s[%0d].data_idle", tag, i - first), 64'(fifo_data_in), 64'd0);
         @(posedge clk);
         #1;
         if (vecs[i].gnt != 4'b0000) prod_word[oh_idx(vecs[i].gnt)] += 32'd1;
      end
      rd_en = 1'b0;
   endtask

   task automatic read_expect(input string tag, input logic [31:0] q[$]);
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         check($sformatf("%s.rd%0d.empty", tag, k), 64'(empty), 64'd0);
         check($sformatf("%s.rd%0d.data", tag, k), 64'(data_out), 64'(q[k]));
         rd_en = 1'b1;
         @(posedge clk);
         #1;
         rd_en = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s.drained", tag), 64'(empty), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      drive_inputs(4'b0000);
      rd_en = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int s_single, s_simul, s_bp, s_fair, s_end;

      // Vector tables: {req, rd, expected gnt, busy, owner_id, full}.
      s_single = vecs.size();
      vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 0, 0));
      for (int k = 0; k < 6; k++) vecs.push_back(mk(4'b0100, 0, 4'b0100, 1, 2, 0));
      vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 2, 0));
      vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 0));

      s_simul = vecs.size();
      vecs.push_back(mk(4'b1111, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b1111, 0, 4'b0001, 1, 0, 0));
      vecs.push_back(mk(4'b1111, 0, 4'b0001, 1, 0, 0));
      vecs.push_back(mk(4'b1110, 0, 4'b0000, 1, 0, 0));
      vecs.push_back(mk(4'b1110, 0, 4'b0010, 1, 1, 0));
      vecs.push_back(mk(4'b1110, 0, 4'b0010, 1, 1, 0));
      vecs.push_back(mk(4'b1100, 0, 4'b0000, 1, 1, 0));
      vecs.push_back(mk(4'b1100, 0, 4'b0100, 1, 2, 0));
      vecs.push_back(mk(4'b1100, 0, 4'b0100, 1, 2, 0));
      vecs.push_back(mk(4'b1000, 0, 4'b0000, 1, 2, 0));
      vecs.push_back(mk(4'b1000, 0, 4'b1000, 1, 3, 0));
      vecs.push_back(mk(4'b1000, 0, 4'b1000, 1, 3, 0));
      vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 3, 1));
      vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1));

      s_bp = vecs.size();
      vecs.push_back(mk(4'b0010, 0, 4'b0000, 0, 0, 1));
      vecs.push_back(mk(4'b0010, 0, 4'b0000, 1, 1, 1));
      vecs.push_back(mk(4'b0010, 0, 4'b0000, 1, 1, 1));
      vecs.push_back(mk(4'b0010, 1, 4'b0000, 1, 1, 1));
      vecs.push_back(mk(4'b0010, 0, 4'b0010, 1, 1, 0));
      vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 1, 1));
      vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1));

      s_fair = vecs.size();
      vecs.push_back(mk(4'b1001, 1, 4'b0000, 0, 0, 0));
      for (int k = 0; k < 4; k++) vecs.push_back(mk(4'b1001, 1, 4'b0001, 1, 0, 0));
      for (int k = 0; k < 4; k++) vecs.push_back(mk(4'b1001, 1, 4'b1000, 1, 3, 0));
      for (int k = 0; k < 4; k++) vecs.push_back(mk(4'b1001, 1, 4'b0001, 1, 0, 0));
      vecs.push_back(mk(4'b1001, 1, 4'b1000, 1, 3, 0));
      vecs.push_back(mk(4'b0000, 1, 4'b0000, 1, 3, 0));
      vecs.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));
      s_end = vecs.size();

      // Reset held with every producer requesting.
      for (int i = 0; i < N; i++) prod_word[i] = 32'(i);
      rst_n = 1'b0;
      rd_en = 1'b0;
      drive_inputs(4'b1111);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst.gnt", 64'(gnt), 64'd0);
      check("rst.wr_en", 64'({fifo_wr_en, fifo_cs}), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.wr_count", 64'(wr_count), 64'd0);
      check("rst.data", 64'(fifo_data_in), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst.bubble_gnt", 64'(gnt), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst.first_gnt", 64'(gnt), 64'b0001);
      check("rst.first_owner", 64'(owner_id), 64'd0);
      #1;
      rst_n = 1'b0;
      drive_inputs(4'b0000);
      #1;
      check("rst.async_gnt", 64'(gnt), 64'd0);
      check("rst.async_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single producer, burst boundary crossed without a gap.
      prod_word[2] = 32'h20;
      run_vecs("single", s_single, s_simul);
      check("single.wr_count", 64'(wr_count), 64'd6);
      exp_q = {};
      for (int k = 0; k < 6; k++) exp_q.push_back(32'h20 + 32'(k));
      read_expect("single", exp_q);

      // All four producers, two words each, fills the FIFO exactly.
      reset_dut();
      for (int i = 0; i < N; i++) prod_word[i] = 32'(i * 16);
      run_vecs("simul", s_simul, s_bp);
      check("simul.wr_count", 64'(wr_count), 64'd8);

      // Back-pressure on the full FIFO, released by one read.
      prod_word[1] = 32'hAA;
      run_vecs("bp", s_bp, s_fair);
      check("bp.wr_count", 64'(wr_count), 64'd9);
      exp_q = {32'h01, 32'h10, 32'h11, 32'h20, 32'h21, 32'h30, 32'h31, 32'hAA};
      read_expect("bp", exp_q);

      // Fairness between two continuous requesters with the FIFO drained.
      reset_dut();
      prod_word[0] = 32'h100;
      prod_word[3] = 32'h300;
      run_vecs("fair", s_fair, s_end);
      check("fair.wr_count", 64'(wr_count), 64'd13);
      @(negedge clk);
      check("fair.empty", 64'(empty), 64'd1);
      @(posedge clk);
      #1;

      // Reset during requester 1's second word.
      reset_dut();
      prod_word[1] = 32'h50;
      drive_inputs(4'b0010);
      @(negedge clk);
      check("mid.bubble", 64'(gnt), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid.word1", 64'(gnt), 64'b0010);
      @(posedge clk);
      #1;
      prod_word[1] = 32'h51;
      drive_inputs(4'b0010);
      @(negedge clk);
      check("mid.word2", 64'(gnt), 64'b0010);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid.rst_gnt", 64'(gnt), 64'd0);
      check("mid.rst_wr_en", 64'(fifo_wr_en), 64'd0);
      check("mid.rst_wr_count", 64'(wr_count), 64'd0);
      check("mid.rst_busy", 64'(busy), 64'd0);
      prod_word[0] = 32'h60;
      drive_inputs(4'b0011);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid.post_bubble", 64'(gnt), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid.post_gnt", 64'(gnt), 64'b0001);
      check("mid.post_owner", 64'(owner_id), 64'd0);
      check("mid.post_data", 64'(fifo_data_in), 64'h60);
      @(posedge clk);
      #1;
      drive_inputs(4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
